// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM state encoding and
// the reset-cause codes that firmware reads back.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    FILTER     = 3'd1,
    REL_PERIPH = 3'd2,
    REL_CPU    = 3'd3,
    RUN        = 3'd4
  } seq_state_e;

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_LOCK = 2'b01;
  localparam logic [1:0] CAUSE_SW   = 2'b10;
  localparam logic [1:0] CAUSE_WDT  = 2'b11;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level; clears to 0 while
// rst_n is low so downstream logic never sees a stale high after reset.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/reset_sequencer.sv
// Qualifies PLL lock, releases peripheral then CPU reset, and re-enters reset on
// lock loss, software request or watchdog expiry, remembering the last cause.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int LOCK_CYCLES  = 16,
  parameter int STAGE_CYCLES = 16,
  parameter int WDT_BITS     = 24,
  parameter bit WDT_EN       = 1'b1
) (
  input  logic       clk25,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       sw_rst_req,
  input  logic       wdt_kick,
  output logic       rst_periph,
  output logic       rst_cpu,
  output logic       ready,
  output logic [1:0] rst_cause
);

  localparam int CNT_W = $clog2(maxInt(LOCK_CYCLES, STAGE_CYCLES));
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);

  seq_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rstPeriph_q;
  logic             rstCpu_q;
  logic             ready_q;
  logic [1:0]       cause_q;
  logic             lockS;
  logic             wdtExpire;
  logic             pastFilter;
  logic             reEnter;

  sync2 uLockSync (
    .clk   (clk25),
    .rst_n (rst_n),
    .d_i   (pll_lock),
    .q_o   (lockS)
  );

  // Watchdog only exists when enabled; unarmed or disabled means it never fires.
  if (WDT_EN) begin : gWdt
    logic [WDT_BITS-1:0] wdtCnt_q;
    logic                wdtArmed_q;

    always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
        wdtCnt_q   <= '0;
        wdtArmed_q <= 1'b0;
      end else if (state_q != RUN) begin
        wdtCnt_q   <= '0;
        wdtArmed_q <= 1'b0;
      end else if (wdt_kick) begin
        wdtCnt_q   <= '0;
        wdtArmed_q <= 1'b1;
      end else if (wdtArmed_q) begin
        wdtCnt_q   <= wdtCnt_q + WDT_BITS'(1);
      end
    end

    assign wdtExpire = (state_q == RUN) && wdtArmed_q && !wdt_kick && (&wdtCnt_q);
  end else begin : gNoWdt
    assign wdtExpire = 1'b0;
  end

  assign pastFilter = (state_q == REL_PERIPH) || (state_q == REL_CPU) || (state_q == RUN);
  assign reEnter    = pastFilter && (!lockS || wdtExpire || sw_rst_req);

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      rstPeriph_q <= 1'b1;
      rstCpu_q    <= 1'b1;
      ready_q     <= 1'b0;
      cause_q     <= CAUSE_POR;
    end else if (reEnter) begin
      // Lock loss outranks watchdog, which outranks the software request.
      rstPeriph_q <= 1'b1;
      rstCpu_q    <= 1'b1;
      ready_q     <= 1'b0;
      cnt_q       <= '0;
      if (!lockS) begin
        cause_q <= CAUSE_LOCK;
        state_q <= WAIT_LOCK;
      end else if (wdtExpire) begin
        cause_q <= CAUSE_WDT;
        state_q <= FILTER;
      end else begin
        cause_q <= CAUSE_SW;
        state_q <= FILTER;
      end
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          cnt_q <= '0;
          if (lockS) begin
            state_q <= FILTER;
          end
        end
        FILTER: begin
          if (!lockS) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_q     <= REL_PERIPH;
            cnt_q       <= '0;
            rstPeriph_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        REL_PERIPH: begin
          if (cnt_q == STAGE_LAST) begin
            state_q <= REL_CPU;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        REL_CPU: begin
          state_q  <= RUN;
          rstCpu_q <= 1'b0;
          ready_q  <= 1'b1;
        end
        RUN: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q     <= WAIT_LOCK;
          cnt_q       <= '0;
          rstPeriph_q <= 1'b1;
          rstCpu_q    <= 1'b1;
          ready_q     <= 1'b0;
        end
      endcase
    end
  end

  assign rst_periph = rstPeriph_q;
  assign rst_cpu    = rstCpu_q;
  assign ready      = ready_q;
  assign rst_cause  = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scenario bench for reset_sequencer: release latencies, re-entry causes,
// watchdog behaviour and asynchronous reset, against arithmetic expectations.
module tb_reset_sequencer;

  localparam int LOCK_CYCLES  = 16;
  localparam int STAGE_CYCLES = 16;
  localparam int WDT_BITS     = 8;

  // Reference timing derived from the behavioural rules: 2 sync edges, one edge
  // to notice lock, then LOCK_CYCLES of qualification; CPU waits the stage plus one.
  localparam int LOCK_REL = 2 + 1 + LOCK_CYCLES;
  localparam int TRIG_REL = LOCK_CYCLES;
  localparam int CPU_REL  = STAGE_CYCLES + 1;
  localparam int WDT_TO   = 1 << WDT_BITS;

  localparam logic [1:0] EXP_POR  = 2'b00;
  localparam logic [1:0] EXP_LOCK = 2'b01;
  localparam logic [1:0] EXP_SW   = 2'b10;
  localparam logic [1:0] EXP_WDT  = 2'b11;

  logic       clk25 = 1'b0;
  logic       rst_n;
  logic       pll_lock;
  logic       sw_rst_req;
  logic       wdt_kick;
  logic       rst_periph;
  logic       rst_cpu;
  logic       ready;
  logic [1:0] rst_cause;

  int checkCount = 0;
  int passCount  = 0;

  reset_sequencer #(
    .LOCK_CYCLES  (LOCK_CYCLES),
    .STAGE_CYCLES (STAGE_CYCLES),
    .WDT_BITS     (WDT_BITS),
    .WDT_EN       (1'b1)
  ) dut (
    .clk25      (clk25),
    .rst_n      (rst_n),
    .pll_lock   (pll_lock),
    .sw_rst_req (sw_rst_req),
    .wdt_kick   (wdt_kick),
    .rst_periph (rst_periph),
    .rst_cpu    (rst_cpu),
    .ready      (ready),
    .rst_cause  (rst_cause)
  );

  always #5 clk25 = ~clk25;

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got no finish want finish");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic tick();
    @(posedge clk25);
    #1;
  endtask

  // Edges until the chosen output reaches val; -1 if the budget runs out.
  task automatic waitLevel(input int sel, input logic val, input int budget, output int n);
    logic s;
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      case (sel)
        0:       s = rst_periph;
        1:       s = rst_cpu;
        default: s = ready;
      endcase
      if (s === val) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pll_lock = 1'b0; sw_rst_req = 1'b0; wdt_kick = 1'b0;
    repeat (5) tick();
    checkCount++;
    if ({rst_periph, rst_cpu, ready, rst_cause} !== 5'b11000)
      $display("[TB] FAIL reset_values: got %b%b%b %b want 110 00", rst_periph, rst_cpu, ready, rst_cause);
    else passCount++;
    rst_n = 1'b1;
  endtask

  task automatic test_por_release();
    int n;
    pll_lock = 1'b1;
    waitLevel(0, 1'b0, 200, n);
    checkCount++;
    if (n !== LOCK_REL) $display("[TB] FAIL por_periph_latency: got %0d want %0d", n, LOCK_REL);
    else passCount++;
    checkCount++;
    if (rst_cpu !== 1'b1 || ready !== 1'b0)
      $display("[TB] FAIL por_cpu_held: got cpu=%b ready=%b want cpu=1 ready=0", rst_cpu, ready);
    else passCount++;
    waitLevel(1, 1'b0, 200, n);
    checkCount++;
    if (n !== CPU_REL) $display("[TB] FAIL por_cpu_latency: got %0d want %0d", n, CPU_REL);
    else passCount++;
    checkCount++;
    if (ready !== 1'b1 || rst_cause !== EXP_POR)
      $display("[TB] FAIL por_run: got ready=%b cause=%b want ready=1 cause=%b", ready, rst_cause, EXP_POR);
    else passCount++;
  endtask

  task automatic test_lock_glitch();
    int n;
    int hi;
    rst_n = 1'b0; pll_lock = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    hi = $urandom_range(15, 1);
    pll_lock = 1'b1;
    repeat (hi) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    waitLevel(0, 1'b0, 200, n);
    checkCount++;
    if (n !== LOCK_REL) $display("[TB] FAIL glitch_requalify (hi=%0d): got %0d want %0d", hi, n, LOCK_REL);
    else passCount++;
    waitLevel(1, 1'b0, 200, n);
    checkCount++;
    if (n !== CPU_REL) $display("[TB] FAIL glitch_cpu_latency: got %0d want %0d", n, CPU_REL);
    else passCount++;
  endtask

  task automatic test_lock_loss();
    repeat ($urandom_range(10, 1)) tick();
    pll_lock = 1'b0;
    repeat (2) tick();
    checkCount++;
    if (rst_periph !== 1'b0 || ready !== 1'b1)
      $display("[TB] FAIL lockloss_early: got periph=%b ready=%b want periph=0 ready=1", rst_periph, ready);
    else passCount++;
    tick();
    checkCount++;
    if ({rst_periph, rst_cpu, ready, rst_cause} !== {3'b110, EXP_LOCK})
      $display("[TB] FAIL lockloss_reset: got %b%b%b %b want 110 %b", rst_periph, rst_cpu, ready, rst_cause, EXP_LOCK);
    else passCount++;
  endtask

  task automatic test_sw_in_filter();
    int n;
    int j;
    pll_lock = 1'b1;
    j = $urandom_range(18, 4);
    repeat (j - 1) tick();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    waitLevel(0, 1'b0, 200, n);
    checkCount++;
    if (n !== LOCK_REL - j) $display("[TB] FAIL sw_in_filter_latency (j=%0d): got %0d want %0d", j, n, LOCK_REL - j);
    else passCount++;
    waitLevel(1, 1'b0, 200, n);
    checkCount++;
    if (n !== CPU_REL || rst_cause !== EXP_LOCK)
      $display("[TB] FAIL sw_in_filter_cause: got lat=%0d cause=%b want lat=%0d cause=%b", n, rst_cause, CPU_REL, EXP_LOCK);
    else passCount++;
  endtask

  task automatic test_sw_reset();
    int n;
    repeat ($urandom_range(20, 1)) tick();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    checkCount++;
    if ({rst_periph, rst_cpu, ready, rst_cause} !== {3'b110, EXP_SW})
      $display("[TB] FAIL sw_reset: got %b%b%b %b want 110 %b", rst_periph, rst_cpu, ready, rst_cause, EXP_SW);
    else passCount++;
    waitLevel(0, 1'b0, 200, n);
    checkCount++;
    if (n !== TRIG_REL) $display("[TB] FAIL sw_periph_latency: got %0d want %0d", n, TRIG_REL);
    else passCount++;
    waitLevel(1, 1'b0, 200, n);
    checkCount++;
    if (n !== CPU_REL) $display("[TB] FAIL sw_cpu_latency: got %0d want %0d", n, CPU_REL);
    else passCount++;
  endtask

  task automatic test_unarmed();
    int hits;
    hits = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (rst_cpu !== 1'b0 || ready !== 1'b1) hits++;
    end
    checkCount++;
    if (hits !== 0) $display("[TB] FAIL unarmed_wdt: got %0d reset cycles want 0", hits);
    else passCount++;
  endtask

  task automatic test_watchdog();
    int n;
    wdt_kick = 1'b1;
    tick();
    wdt_kick = 1'b0;
    waitLevel(0, 1'b1, 2 * WDT_TO, n);
    checkCount++;
    if (n !== WDT_TO) $display("[TB] FAIL wdt_timeout: got %0d want %0d", n, WDT_TO);
    else passCount++;
    checkCount++;
    if (rst_cpu !== 1'b1 || ready !== 1'b0 || rst_cause !== EXP_WDT)
      $display("[TB] FAIL wdt_cause: got cpu=%b ready=%b cause=%b want cpu=1 ready=0 cause=%b", rst_cpu, ready, rst_cause, EXP_WDT);
    else passCount++;
    waitLevel(0, 1'b0, 200, n);
    checkCount++;
    if (n !== TRIG_REL) $display("[TB] FAIL wdt_periph_latency: got %0d want %0d", n, TRIG_REL);
    else passCount++;
    waitLevel(1, 1'b0, 200, n);
    checkCount++;
    if (n !== CPU_REL) $display("[TB] FAIL wdt_cpu_latency: got %0d want %0d", n, CPU_REL);
    else passCount++;
  endtask

  task automatic test_kicking();
    int hits;
    int gap;
    hits = 0;
    for (int k = 0; k < 10; k++) begin
      gap = (k == 0) ? 200 : $urandom_range(WDT_TO - 6, 1);
      wdt_kick = 1'b1;
      tick();
      wdt_kick = 1'b0;
      if (rst_cpu !== 1'b0) hits++;
      for (int i = 1; i < gap; i++) begin
        tick();
        if (rst_cpu !== 1'b0) hits++;
      end
    end
    checkCount++;
    if (hits !== 0) $display("[TB] FAIL kicked_wdt: got %0d reset cycles want 0", hits);
    else passCount++;
  endtask

  task automatic test_simultaneous();
    int n;
    // Watchdog expiry and software request together: watchdog wins.
    wdt_kick = 1'b1;
    tick();
    wdt_kick = 1'b0;
    repeat (WDT_TO - 1) tick();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    checkCount++;
    if (rst_periph !== 1'b1 || rst_cause !== EXP_WDT)
      $display("[TB] FAIL wdt_over_sw: got periph=%b cause=%b want periph=1 cause=%b", rst_periph, rst_cause, EXP_WDT);
    else passCount++;
    waitLevel(2, 1'b1, 200, n);
    // All three triggers land on one edge: lock loss wins.
    wdt_kick = 1'b1;
    tick();
    wdt_kick = 1'b0;
    repeat (WDT_TO - 3) tick();
    pll_lock = 1'b0;
    repeat (2) tick();
    sw_rst_req = 1'b1;
    checkCount++;
    if (rst_periph !== 1'b0 || ready !== 1'b1)
      $display("[TB] FAIL triple_early: got periph=%b ready=%b want periph=0 ready=1", rst_periph, ready);
    else passCount++;
    tick();
    sw_rst_req = 1'b0;
    checkCount++;
    if ({rst_periph, rst_cpu, ready, rst_cause} !== {3'b110, EXP_LOCK})
      $display("[TB] FAIL triple_cause: got %b%b%b %b want 110 %b", rst_periph, rst_cpu, ready, rst_cause, EXP_LOCK);
    else passCount++;
    pll_lock = 1'b1;
    waitLevel(0, 1'b0, 200, n);
    checkCount++;
    if (n !== LOCK_REL) $display("[TB] FAIL triple_requalify: got %0d want %0d", n, LOCK_REL);
    else passCount++;
  endtask

  task automatic test_async_reset();
    int n;
    repeat ($urandom_range(10, 1)) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkCount++;
    if ({rst_periph, rst_cpu, ready, rst_cause} !== {3'b110, EXP_POR})
      $display("[TB] FAIL async_reset: got %b%b%b %b want 110 %b", rst_periph, rst_cpu, ready, rst_cause, EXP_POR);
    else passCount++;
    tick();
    rst_n = 1'b1;
    waitLevel(0, 1'b0, 200, n);
    checkCount++;
    if (n !== LOCK_REL) $display("[TB] FAIL async_rerelease: got %0d want %0d", n, LOCK_REL);
    else passCount++;
    waitLevel(1, 1'b0, 200, n);
    checkCount++;
    if (n !== CPU_REL || rst_cause !== EXP_POR)
      $display("[TB] FAIL async_run: got lat=%0d cause=%b want lat=%0d cause=%b", n, rst_cause, CPU_REL, EXP_POR);
    else passCount++;
  endtask

  initial begin
    test_reset();
    test_por_release();
    test_lock_glitch();
    test_lock_loss();
    test_sw_in_filter();
    test_sw_reset();
    test_unarmed();
    test_watchdog();
    test_kicking();
    test_simultaneous();
    test_async_reset();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
